// File: rtl/refresh_pkg.sv
// Shared definitions for the refresh scheduler: FSM state type,
// default timing constants and a small saturating-counter helper.
package refresh_pkg;

  localparam int ROW_WIDTH_DEFAULT    = 16;
  localparam int T_REFI_DEFAULT       = 7800;
  localparam int MAX_POSTPONE_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    QUERY     = 2'd1,
    WAIT_DREF = 2'd2,
    ISSUE     = 2'd3
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/refi_timer.sv
// Refresh interval timer: counts enabled cycles modulo T_REFI and
// raises tick for the single cycle in which the count is T_REFI-1.
module refi_timer
  import refresh_pkg::*;
#(
  parameter int T_REFI = T_REFI_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int               CNT_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(T_REFI - 1);

  logic [CNT_W-1:0] cnt;

  // A disabled timer holds its count, so tick is gated by en to avoid
  // repeated ticks while parked on the last value.
  assign tick = en && (cnt == LAST);

  // Interval counter: wraps on tick, advances while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: accumulates refresh slots from the interval timer,
// walks a row pointer, asks the WUPR stage whether each row needs a
// refresh, and either skips the row or requests a refresh command.
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int ROW_WIDTH    = ROW_WIDTH_DEFAULT,
  parameter int T_REFI       = T_REFI_DEFAULT,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 refresh_en,
  output logic                 to_refresh,
  output logic [ROW_WIDTH-1:0] Ra,
  input  logic                 dref,
  output logic                 ref_req,
  output logic [ROW_WIDTH-1:0] ref_row,
  input  logic                 ref_ack,
  output logic                 round_done,
  output logic [15:0]          skip_cnt,
  output logic                 overflow
);

  localparam int                   PEND_W   = $clog2(MAX_POSTPONE + 1);
  localparam logic [PEND_W-1:0]    PEND_MAX = PEND_W'(MAX_POSTPONE);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST = '1;

  state_e                 state;
  state_e                 state_nxt;
  logic                   tick;
  logic [PEND_W-1:0]      pending;
  logic [ROW_WIDTH-1:0]   row_ptr;
  logic                   skip_done;
  logic                   issue_done;
  logic                   row_done;

  refi_timer #(
    .T_REFI (T_REFI)
  ) u_refi_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (refresh_en),
    .tick  (tick)
  );

  // A row completes either by being skipped (WUPR says no refresh needed)
  // or by the arbiter accepting its refresh request. ref_ack outside
  // ISSUE never reaches this term, so stray acks are ignored.
  assign skip_done  = (state == WAIT_DREF) && !dref;
  assign issue_done = (state == ISSUE) && ref_ack;
  assign row_done   = skip_done || issue_done;

  // Outputs decode straight from the state register, so an async reset
  // drops ref_req in the same cycle. QUERY and ISSUE are exclusive states,
  // which keeps to_refresh and ref_req from ever overlapping.
  assign to_refresh = (state == QUERY);
  assign ref_req    = (state == ISSUE);
  assign Ra         = to_refresh ? row_ptr : '0;
  assign ref_row    = ref_req ? row_ptr : '0;

  // Next-state logic for the per-row query/issue sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pending != '0) state_nxt = QUERY;
      QUERY:     state_nxt = WAIT_DREF;
      WAIT_DREF: state_nxt = dref ? ISSUE : IDLE;
      ISSUE:     if (ref_ack) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Postponed-slot budget: tick adds, completion removes, both cancel.
  // A tick that finds the budget full is dropped and latches overflow,
  // which only reset clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else if (tick && !row_done) begin
      if (pending == PEND_MAX) begin
        overflow <= 1'b1;
      end else begin
        pending <= pending + 1'b1;
      end
    end else if (row_done && !tick) begin
      pending <= pending - 1'b1;
    end
  end

  // Row pointer, skip statistics and the end-of-round pulse, which lands
  // in the cycle after the last row of the address space completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_ptr    <= '0;
      skip_cnt   <= '0;
      round_done <= 1'b0;
    end else begin
      round_done <= row_done && (row_ptr == ROW_LAST);
      if (row_done) begin
        row_ptr <= row_ptr + 1'b1;
      end
      if (skip_done) begin
        skip_cnt <= sat_inc16(skip_cnt);
      end
    end
  end

endmodule

// File: doc/refresh_scheduler.md
REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

Interface
REQ-001 Parameters SHALL be:
- ROW_WIDTH, 16, row address width.
- T_REFI, 7800, refresh interval in clk cycles.
- MAX_POSTPONE, 8, maximum queued refresh slots.
REQ-002 Clocking and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- refresh_en  in  1  enables interval timer.
- to_refresh  out  1  one-cycle query strobe to the WUPR stage.
- Ra  out  ROW_WIDTH  row being queried; valid while to_refresh=1.
- dref  in  1  WUPR decision, 1 = row needs refresh.
- ref_req  out  1  refresh command request to the command arbiter.
- ref_row  out  ROW_WIDTH  row for ref_req.
- ref_ack  in  1  arbiter accepts the request.
- round_done  out  1  one-cycle pulse when the row pointer wraps.
- skip_cnt  out  16  saturating count of skipped rows.
- overflow  out  1  sticky flag, postpone budget exceeded.

Function
REQ-004 Interval counter SHALL count 0..T_REFI-1 while refresh_en=1 and hold while refresh_en=0.
REQ-005 A tick SHALL occur in the cycle the interval counter equals T_REFI-1; the counter then wraps to 0.
REQ-006 pending (0..MAX_POSTPONE) SHALL be +1 on tick, -1 on row completion, and unchanged when both occur in the same cycle.
REQ-007 A tick with pending=MAX_POSTPONE and no completion in that cycle SHALL leave pending saturated and set overflow.
REQ-008 FSM states SHALL be IDLE, QUERY, WAIT_DREF, ISSUE.
REQ-009 In IDLE with pending>0, the FSM SHALL go to QUERY; otherwise it SHALL stay in IDLE.
REQ-010 In QUERY (one cycle), to_refresh=1 and Ra=row_ptr; the FSM SHALL then go to WAIT_DREF.
REQ-011 WAIT_DREF (one cycle) SHALL sample dref: dref=1 -> ISSUE; dref=0 -> skip completion and return to IDLE.
REQ-012 On skip completion: row_ptr+1, pending-1, skip_cnt+1 (saturating at 0xFFFF).
REQ-013 In ISSUE, ref_req=1 and ref_row=row_ptr SHALL be held stable until ref_ack=1.
REQ-014 When ref_req=1 and ref_ack=1 in the same cycle: completion (row_ptr+1, pending-1) and return to IDLE.
REQ-015 ref_ack while not in ISSUE SHALL be ignored.
REQ-016 row_ptr SHALL wrap from 2^ROW_WIDTH-1 to 0, and round_done SHALL pulse in the cycle after the wrap completion.
REQ-017 Latency: tick in cycle t -> to_refresh in t+2 -> dref sampled in t+3 -> ref_req from t+4.
REQ-018 refresh_en=0 SHALL NOT abort an in-flight row; queued pending rows SHALL still drain.
REQ-019 to_refresh and ref_req SHALL never be asserted in the same cycle.

Reset
REQ-020 On rst_n low, asynchronously:
- FSM=IDLE.
- interval counter, pending, row_ptr, skip_cnt = 0.
- to_refresh, ref_req, round_done, overflow = 0.
- Ra and ref_row = 0.
REQ-021 Reset mid-ISSUE SHALL drop ref_req immediately; the row is not completed.
REQ-022 Reset is the only clear for overflow.

Structure
REQ-023 The FSM state enum and default T_REFI/MAX_POSTPONE constants SHALL reside in shared package refresh_pkg.
REQ-024 The interval counter plus tick SHALL be sub-module refi_timer; all other logic SHALL be in refresh_scheduler.

Verification
REQ-025 The bench SHALL cover these directed scenarios, all with T_REFI=16 and ref_ack tied high:
- Reset release, refresh_en=1, dref=1 -> first to_refresh at cycle 17 with Ra=0, ref_req at cycle 19 with ref_row=0.
- dref=0 for rows 0..3 -> no ref_req, skip_cnt=4, next query Ra=4.
- ref_ack held low 100 cycles, dref=1 -> ref_req and ref_row stable throughout, pending reaches 6, no overflow.
- ref_ack held low >9 intervals -> overflow=1 sticky; ack release drains pending to 0.
- ROW_WIDTH=4, dref=0 -> Ra sequence 15 then 0, round_done single pulse.
- rst_n asserted while ref_req=1 -> ref_req=0 in the same cycle, all outputs at reset values.
